f_fetch_ctrl: RTL and testbench

// - F-stage fetch sequencer: owns the fetch PC register and drives instruction-memory requests.
// - Arbitrates next-PC sources: interrupt > eret > D-stage branch/jump redirect > sequential PC+4.
// - Redirects that arrive while a fetch is outstanding are buffered until that fetch completes.
// - Sits between the D-stage next-PC logic, the CP0/exception unit, the hazard unit and IM.

---
 rtl/f_fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_f_fetch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_ctrl.sv
// F-stage fetch sequencer: owns the fetch PC, issues IM requests, buffers redirects.
// Optional fetch-address legality check is enabled by defining FETCH_ADDR_CHECK_EN.
module f_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] INT_VEC  = 32'h0000_4180,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_int_req,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    input  logic        i_br_redirect,
    input  logic [31:0] i_br_target,
    output logic        o_if_req,
    output logic [31:0] o_if_addr,
    input  logic        i_if_ack,
    output logic [31:0] o_pc,
    output logic        o_flush_f,
    output logic        o_pend,
    output logic        o_exc_adel
);

    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_REQ, S_PEND} state_e;

    // Redirect kinds double as priorities, so a plain compare arbitrates them.
    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_BR   = 2'd1;
    localparam logic [1:0] P_ERET = 2'd2;
    localparam logic [1:0] P_INT  = 2'd3;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt_q;
    logic [1:0]  pend_prio_q;

    logic [1:0]  new_prio;
    logic [31:0] new_tgt;
    logic        pend_take;
    logic [1:0]  app_prio;
    logic [31:0] app_tgt;
    state_e      busy_d;

    always_comb begin
        new_prio = P_NONE;
        new_tgt  = i_br_target;
        if (i_int_req) begin
            new_prio = P_INT;
            new_tgt  = INT_VEC;
        end else if (i_eret) begin
            new_prio = P_ERET;
            new_tgt  = i_epc;
        end else if (i_br_redirect) begin
            new_prio = P_BR;
        end
    end

    // In PEND a newer redirect of equal or higher priority supersedes the buffered one.
    always_comb begin
        pend_take = (new_prio != P_NONE) && (new_prio >= pend_prio_q);
        app_prio  = new_prio;
        app_tgt   = new_tgt;
        if (state_q == S_PEND && !pend_take) begin
            app_prio = pend_prio_q;
            app_tgt  = pend_tgt_q;
        end
        busy_d = i_stall ? S_IDLE : S_REQ;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            pend_tgt_q  <= '0;
            pend_prio_q <= P_NONE;
        end else begin
            case (state_q)
                S_BOOT, S_IDLE: begin
                    if (new_prio != P_NONE) pc_q <= new_tgt;
                    state_q <= busy_d;
                end
                S_REQ: begin
                    if (i_if_ack) begin
                        pc_q    <= (app_prio != P_NONE) ? app_tgt : pc_q + 32'd4;
                        state_q <= busy_d;
                    end else if (new_prio != P_NONE) begin
                        pend_tgt_q  <= new_tgt;
                        pend_prio_q <= new_prio;
                        state_q     <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (i_if_ack) begin
                        pc_q        <= app_tgt;
                        pend_prio_q <= P_NONE;
                        state_q     <= busy_d;
                    end else if (pend_take) begin
                        pend_tgt_q  <= new_tgt;
                        pend_prio_q <= new_prio;
                    end
                end
                default: state_q <= S_BOOT;
            endcase
        end
    end

    assign o_if_req  = (state_q == S_REQ) || (state_q == S_PEND);
    assign o_if_addr = pc_q;
    assign o_pc      = pc_q;
    assign o_pend    = (state_q == S_PEND);
    assign o_flush_f = i_if_ack && o_if_req && (app_prio >= P_ERET);

`ifdef FETCH_ADDR_CHECK_EN
    assign o_exc_adel = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
`else
    assign o_exc_adel = 1'b0;
`endif

endmodule

// File: tb/tb_f_fetch_ctrl.sv
// Bench for f_fetch_ctrl: directed vector table, hand-written corner sequences, random run vs model.
module tb_f_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        int_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] epc = '0;
    logic        br = 1'b0;
    logic [31:0] br_tgt = '0;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack = 1'b0;
    logic [31:0] pc;
    logic        flush_f;
    logic        pend;
    logic        exc_adel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    f_fetch_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_int_req(int_req),
        .i_eret(eret), .i_epc(epc), .i_br_redirect(br), .i_br_target(br_tgt),
        .o_if_req(if_req), .o_if_addr(if_addr), .i_if_ack(if_ack), .o_pc(pc),
        .o_flush_f(flush_f), .o_pend(pend), .o_exc_adel(exc_adel)
    );

    // Reference model: is a fetch outstanding, and is a redirect waiting for it.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_pv;
    logic [31:0] m_pt;
    int          m_pp;

    typedef struct {
        bit          int_req, eret, br, ack, stall;
        logic [31:0] epc, tgt;
        bit          exp_req, exp_flush, exp_pend;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_adel(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h6FFC);
`else
        return a !== a;
`endif
    endfunction

    task automatic model_reset();
        m_pc  = 32'h3000;
        m_out = 0;
        m_pv  = 0;
        m_pt  = '0;
        m_pp  = 0;
    endtask

    // One clock: drive at negedge, compare with the model, then advance the model.
    task automatic cycle(input bit i_int, input bit i_er, input logic [31:0] i_epc,
                         input bit i_br, input logic [31:0] i_tgt, input bit i_ack,
                         input bit i_st);
        int          np, ap;
        logic [31:0] nt, at;
        @(negedge clk);
        int_req = i_int; eret = i_er; epc = i_epc; br = i_br; br_tgt = i_tgt;
        if_ack = i_ack; stall = i_st;
        #1;
        np = i_int ? 3 : i_er ? 2 : i_br ? 1 : 0;
        nt = i_int ? 32'h4180 : i_er ? i_epc : i_tgt;
        if (m_pv && !(np != 0 && np >= m_pp)) begin
            ap = m_pp; at = m_pt;
        end else begin
            ap = np; at = nt;
        end
        chk("if_req", {31'b0, if_req}, {31'b0, m_out});
        chk("if_addr", if_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("pend", {31'b0, pend}, {31'b0, m_pv});
        chk("flush_f", {31'b0, flush_f}, {31'b0, (m_out && i_ack && ap >= 2)});
        chk("exc_adel", {31'b0, exc_adel}, {31'b0, exp_adel(m_pc)});
        if (!m_out) begin
            if (np != 0) m_pc = nt;
            m_out = !i_st;
        end else if (i_ack) begin
            m_pc  = (ap != 0) ? at : m_pc + 32'd4;
            m_pv  = 0;
            m_pp  = 0;
            m_out = !i_st;
        end else if (np != 0 && (!m_pv || np >= m_pp)) begin
            m_pv = 1; m_pt = nt; m_pp = np;
        end
    endtask

    task automatic do_reset(input bit st);
        @(negedge clk);
        rst_n = 1'b0;
        int_req = 0; eret = 0; br = 0; if_ack = 0; stall = st;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic vec_t mk(bit i, bit e, logic [31:0] ep, bit b, logic [31:0] t, bit a,
                                bit rq, logic [31:0] ad, bit fl, bit pd);
        vec_t v;
        v.int_req = i; v.eret = e; v.epc = ep; v.br = b; v.tgt = t; v.ack = a; v.stall = 0;
        v.exp_req = rq; v.exp_addr = ad; v.exp_flush = fl; v.exp_pend = pd;
        return v;
    endfunction

    initial begin
        // Directed sequence from reset, expected values written out by hand.
        vecs[0]  = mk(0, 0, 0,        0, 0,        1, 0, 32'h3000, 0, 0);
        vecs[1]  = mk(0, 0, 0,        0, 0,        1, 1, 32'h3000, 0, 0);
        vecs[2]  = mk(0, 0, 0,        0, 0,        1, 1, 32'h3004, 0, 0);
        vecs[3]  = mk(0, 0, 0,        1, 32'h3100, 0, 1, 32'h3008, 0, 0);
        vecs[4]  = mk(0, 0, 0,        0, 0,        0, 1, 32'h3008, 0, 1);
        vecs[5]  = mk(0, 0, 0,        0, 0,        0, 1, 32'h3008, 0, 1);
        vecs[6]  = mk(0, 0, 0,        0, 0,        1, 1, 32'h3008, 0, 1);
        vecs[7]  = mk(1, 1, 32'h3200, 0, 0,        1, 1, 32'h3100, 1, 0);
        vecs[8]  = mk(0, 0, 0,        1, 32'h3100, 0, 1, 32'h4180, 0, 0);
        vecs[9]  = mk(0, 1, 32'h3400, 0, 0,        0, 1, 32'h4180, 0, 1);
        vecs[10] = mk(0, 0, 0,        1, 32'h3500, 0, 1, 32'h4180, 0, 1);
        vecs[11] = mk(0, 0, 0,        0, 0,        1, 1, 32'h4180, 1, 1);
        vecs[12] = mk(0, 0, 0,        0, 0,        0, 1, 32'h3400, 0, 0);

        do_reset(0);
        chk("reset_pc", pc, 32'h3000);
        chk("reset_req", {31'b0, if_req}, 32'h0);
        for (int k = 0; k < 13; k++) begin
            cycle(vecs[k].int_req, vecs[k].eret, vecs[k].epc, vecs[k].br, vecs[k].tgt,
                  vecs[k].ack, vecs[k].stall);
            chk($sformatf("vec%0d_req", k), {31'b0, if_req}, {31'b0, vecs[k].exp_req});
            chk($sformatf("vec%0d_addr", k), if_addr, vecs[k].exp_addr);
            chk($sformatf("vec%0d_flush", k), {31'b0, flush_f}, {31'b0, vecs[k].exp_flush});
            chk($sformatf("vec%0d_pend", k), {31'b0, pend}, {31'b0, vecs[k].exp_pend});
        end

        // Reset while a redirect is buffered: request and pending drop at once.
        cycle(0, 0, 0, 1, 32'h3600, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_req", {31'b0, if_req}, 32'h0);
        chk("midreset_pend", {31'b0, pend}, 32'h0);
        chk("midreset_pc", pc, 32'h3000);

        // Stalled from reset, interrupt while idle, then release.
        do_reset(1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("idle_req", {31'b0, if_req}, 32'h0);
        chk("idle_pc", pc, 32'h3000);
        cycle(1, 0, 0, 0, 0, 1, 1);
        chk("idle_int_flush", {31'b0, flush_f}, 32'h0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("idle_int_pc", pc, 32'h4180);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("release_req", {31'b0, if_req}, 32'h1);
        chk("release_addr", if_addr, 32'h4180);

        // Address check corner cases: misaligned and above the legal window.
        cycle(0, 0, 0, 1, 32'h3102, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("adel_misaligned", {31'b0, exc_adel}, {31'b0, exp_adel(32'h3102)});
        cycle(0, 0, 0, 1, 32'h7000, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("adel_high", {31'b0, exc_adel}, {31'b0, exp_adel(32'h7000)});

        // Random run against the model.
        do_reset(0);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t1, t2;
            t1 = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            t2 = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            if ($urandom_range(0, 15) == 0) t1 = $urandom;
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, t2,
                  $urandom_range(0, 4) == 0, t1, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 400) == 0) do_reset($urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
